// File: rtl/g05_truth_table_checker.sv
// Sweeps all 2^N input vectors, holds each SETTLE cycles, samples once, and compares dut_a against dut_b.
// Optional TT_CHECKER_STOP_ON_FAIL_EN aborts the sweep at the first mismatch; start is honoured only in IDLE.
module g05_truth_table_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_dut_a,
  input  logic         i_dut_b,
  output logic [N-1:0] o_vec_out,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_pass,
  output logic [N:0]   o_mismatch_count,
  output logic [N-1:0] o_first_fail_vec,
  output logic         o_first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [N-1:0] LAST_VEC   = '1;
  localparam logic [3:0]   SETTLE_RLD = 4'(SETTLE - 1);
  localparam logic [N:0]   CNT_MAX    = {1'b1, {N{1'b0}}};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_vec;
  logic [3:0]   r_settle;
  logic [N:0]   r_cnt;
  logic [N:0]   w_cnt_nxt;
  logic [N-1:0] r_ff_vec;
  logic         r_ff_vld;
  logic         r_pass;
  logic         w_mismatch;
  logic         w_stop;
  logic         w_last;

  // Case inequality so an X/Z from either model is reported rather than hidden.
  assign w_mismatch = (i_dut_a !== i_dut_b);
  assign w_last     = (r_vec == LAST_VEC);

`ifdef TT_CHECKER_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_mismatch && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + (N+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_DRIVE;
      S_DRIVE:  if (r_settle == 4'd0) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = (w_last || w_stop) ? S_DONE : S_DRIVE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vec    <= '0;
      r_settle <= 4'd0;
      r_cnt    <= '0;
      r_ff_vec <= '0;
      r_ff_vld <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_vec    <= '0;
            r_settle <= SETTLE_RLD;
            r_cnt    <= '0;
            r_ff_vld <= 1'b0;
            r_pass   <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (r_settle != 4'd0) begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_SAMPLE: begin
          r_cnt <= w_cnt_nxt;
          if (w_mismatch && !r_ff_vld) begin
            r_ff_vec <= r_vec;
            r_ff_vld <= 1'b1;
          end
          // Verdict includes the mismatch seen on this final sample.
          if (w_state_nxt == S_DONE) begin
            r_pass <= (w_cnt_nxt == '0);
          end else begin
            r_vec    <= r_vec + N'(1);
            r_settle <= SETTLE_RLD;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_vec_out          = r_vec;
  assign o_busy             = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
  assign o_done             = (r_state == S_DONE);
  assign o_pass             = r_pass;
  assign o_mismatch_count   = r_cnt;
  assign o_first_fail_vec   = r_ff_vec;
  assign o_first_fail_valid = r_ff_vld;

endmodule

// File: tb/tb_g05_truth_table_checker.sv
// Bench for g05_truth_table_checker: table vectors plus random fault masks, SETTLE=1 and SETTLE=3 instances.
module tb_g05_truth_table_checker;

`ifdef TT_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st1 = 1'b0, st3 = 1'b0;
  logic [3:0] mask1 = '0, mask3 = '0;
  logic       gl1 = 1'b0, gl3 = 1'b0;
  logic       a1, b1, a3, b3;
  logic [1:0] vec1, vec3, ff1, ff3;
  logic [2:0] cnt1, cnt3;
  logic       busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3;

  // Implementation A is x|~y; B is A corrupted by a per-vector fault mask and an optional glitch.
  always_comb begin
    a1 = vec1[1] | ~vec1[0];
    b1 = a1 ^ mask1[vec1] ^ gl1;
    a3 = vec3[1] | ~vec3[0];
    b3 = a3 ^ mask3[vec3] ^ gl3;
  end

  g05_truth_table_checker #(.N(2), .SETTLE(1)) u_s1 (
    .i_clk(clk), .i_reset(rst), .i_start(st1), .i_dut_a(a1), .i_dut_b(b1),
    .o_vec_out(vec1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_mismatch_count(cnt1), .o_first_fail_vec(ff1), .o_first_fail_valid(ffv1));

  g05_truth_table_checker #(.N(2), .SETTLE(3)) u_s3 (
    .i_clk(clk), .i_reset(rst), .i_start(st3), .i_dut_a(a3), .i_dut_b(b3),
    .o_vec_out(vec3), .o_busy(busy3), .o_done(done3), .o_pass(pass3),
    .o_mismatch_count(cnt3), .o_first_fail_vec(ff3), .o_first_fail_valid(ffv3));

  int cur_sel = 0;
  logic [1:0] o_vec, o_ff;
  logic [2:0] o_cnt;
  logic       o_busy, o_done, o_pass, o_ffv;
  always_comb begin
    o_vec  = cur_sel != 0 ? vec3  : vec1;
    o_ff   = cur_sel != 0 ? ff3   : ff1;
    o_cnt  = cur_sel != 0 ? cnt3  : cnt1;
    o_busy = cur_sel != 0 ? busy3 : busy1;
    o_done = cur_sel != 0 ? done3 : done1;
    o_pass = cur_sel != 0 ? pass3 : pass1;
    o_ffv  = cur_sel != 0 ? ffv3  : ffv1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) st3 = v; else st1 = v;
  endtask

  task automatic set_glitch(input int sel, input logic v);
    if (sel != 0) gl3 = v; else gl1 = v;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_vec"},  o_vec,  0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_cnt"},  o_cnt,  0);
    chk({tag, "_ff"},   o_ff,   0);
    chk({tag, "_ffv"},  o_ffv,  0);
  endtask

  // Reference model: mismatches are simply the set bits of the fault mask.
  task automatic model(input logic [3:0] mask, output int cnt, output int first, output int valid);
    cnt = 0; first = 0; valid = 0;
    for (int v = 0; v < 4; v++) begin
      if (mask[v]) begin
        if (valid == 0) first = v;
        valid = 1;
        cnt++;
      end
    end
  endtask

  // Full-sweep expectations are passed in; the early-abort variant is derived from them here.
  task automatic run_sweep(input int sel, input logic [3:0] mask, input logic gl, input int hold,
                           input int f_cnt, input int f_first, input int f_valid);
    int s, nv, m, c, e_cnt, e_end;
    bit seen;
    s = (sel != 0) ? 3 : 1;
    nv = (STOP && f_valid != 0) ? f_first + 1 : 4;
    m = nv * (s + 1);
    e_cnt = STOP ? f_valid : f_cnt;
    e_end = nv - 1;
    cur_sel = sel;
    if (sel != 0) mask3 = mask; else mask1 = mask;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    if (hold == 0) set_start(sel, 1'b0);
    c = 0; seen = 0;
    while (c <= 200 && !seen) begin
      set_glitch(sel, gl && ((c % (s + 1)) != s));
      #1;
      if (o_done) seen = 1;
      else if (c < m) begin
        chk("busy_in_sweep", o_busy, 1);
        chk("vec_walk", o_vec, c / (s + 1));
      end
      if (!seen) begin
        @(posedge clk); #1;
        c++;
      end
    end
    set_glitch(sel, 1'b0);
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_cycle", c, m);
      chk("busy_at_done", o_busy, 0);
      chk("cnt", o_cnt, e_cnt);
      chk("ffv", o_ffv, f_valid);
      if (f_valid != 0) chk("ff_vec", o_ff, f_first);
      chk("pass", o_pass, f_valid == 0);
      chk("vec_end", o_vec, e_end);
      @(posedge clk); #1;
      chk("done_one_cycle", o_done, 0);
      chk("idle_not_busy", o_busy, 0);
      chk("cnt_held", o_cnt, e_cnt);
      chk("pass_held", o_pass, f_valid == 0);
      if (hold != 0) begin
        @(posedge clk); #1;
        chk("restart_in_idle", o_busy, 1);
        chk("restart_vec0", o_vec, 0);
        chk("restart_cnt0", o_cnt, 0);
        set_start(sel, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
  endtask

  typedef struct {
    int         sel;
    logic [3:0] mask;
    logic       gl;
    int         hold;
    int         cnt;
    int         first;
    int         valid;
  } tv_t;

  tv_t tbl[7];

  initial begin
    int c, e_cnt, e_first, e_valid, sel;
    logic [3:0] msk;
    // Fault mask 4'b1101 makes B constant 0, since x|~y is 1,0,1,1 over 00..11.
    tbl[0] = '{0, 4'b0000, 1'b0, 0, 0, 0, 0};
    tbl[1] = '{0, 4'b1101, 1'b0, 0, 3, 0, 1};
    tbl[2] = '{1, 4'b0000, 1'b1, 0, 0, 0, 0};
    tbl[3] = '{1, 4'b1000, 1'b1, 0, 1, 3, 1};
    tbl[4] = '{0, 4'b0110, 1'b0, 0, 2, 1, 1};
    tbl[5] = '{1, 4'b1111, 1'b0, 0, 4, 0, 1};
    tbl[6] = '{0, 4'b0000, 1'b0, 1, 0, 0, 0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cur_sel = 0; #1; check_reset_values("rst1");
    cur_sel = 1; #1; check_reset_values("rst3");
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_sweep(tbl[i].sel, tbl[i].mask, tbl[i].gl, tbl[i].hold,
                tbl[i].cnt, tbl[i].first, tbl[i].valid);
    end

    // Reset at vector 10 mid-sweep, with start also high to show reset priority.
    cur_sel = 0;
    mask1 = 4'b1101;
    st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    c = 0;
    while (vec1 != 2'b10 && busy1 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reached_vec10", vec1, 2);
    rst = 1'b1;
    st1 = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst = 1'b0;
    st1 = 1'b0;
    run_sweep(0, 4'b1101, 1'b0, 0, 3, 0, 1);

    for (int i = 0; i < 12; i++) begin
      msk = 4'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 1));
      model(msk, e_cnt, e_first, e_valid);
      run_sweep(sel, msk, 1'($urandom_range(0, 1)), 0, e_cnt, e_first, e_valid);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/g05_truth_table_checker.md
# g05_truth_table_checker

Self-checking sequencer for two-input (generally N-input) combinational units: it sweeps every input vector, drives it onto a unit under check, waits a settle interval, and compares the outputs of two implementations, for example an expression model against a NOR-only gate model. It sits beside the Guia 05 logic modules and replaces hand-written `#1` stimulus with a clocked, repeatable pass/fail sweep that also runs on FPGA.

## Interface
- `N`, default 2: number of unit inputs; swept vectors are 0 .. 2^N-1.
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high; reset is synchronous and active-high.
- `start`  in  1: request a sweep; honoured only in IDLE.
- `dut_a`  in  1: output of implementation A (expression model).
- `dut_b`  in  1: output of implementation B (gate-level model).
- `vec_out`  out  N: vector driven to both implementations; bit N-1 = first operand (x), bit 0 = last (y).
- `busy`  out  1: high while in DRIVE or SAMPLE.
- `done`  out  1: one-cycle pulse when the sweep ends.
- `pass`  out  1: 1 when the last completed sweep had zero mismatches; held until next start.
- `mismatch_count`  out  N+1: mismatches found in current/last sweep (max 2^N, never wraps).
- `first_fail_vec`  out  N: first vector that mismatched.
- `first_fail_valid`  out  1: `first_fail_vec` holds a valid value.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: `start`=1 leads to DRIVE. On the same edge: `vec_out`=0, settle counter=SETTLE-1, `mismatch_count`=0, `first_fail_valid`=0, `pass`=0.
- DRIVE: settle counter decrements each cycle. Move to SAMPLE on the edge where it is 0, so DRIVE lasts exactly SETTLE cycles.
- SAMPLE: mismatch is `dut_a != dut_b`. An X/Z on either input counts as a mismatch in simulation (compare with `!==`).
  - On a mismatch, `mismatch_count` increments. If `first_fail_valid`=0, capture `vec_out` and set `first_fail_valid`.
  - If `vec_out` = 2^N-1, go to DONE.
  - Otherwise `vec_out` increments, the settle counter reloads to SETTLE-1, and the FSM returns to DRIVE.
- DONE: `done`=1 for this cycle only. `pass` = (`mismatch_count`==0), registered on entry. Next state is IDLE.
- `vec_out` holds its last value in DONE and IDLE.
- `start` is ignored in DRIVE, SAMPLE and DONE; it is not queued.
- Reset values: state IDLE, `vec_out`=0, `busy`=0, `done`=0, `pass`=0, `mismatch_count`=0, `first_fail_vec`=0, `first_fail_valid`=0.
- Reset asserted mid-sweep discards the sweep; every output takes its reset value on that edge.
- Reset has priority over `start` when both are high.

## Timing
- Each vector takes SETTLE+1 cycles (DRIVE×SETTLE, then SAMPLE×1).
- If `start` is sampled at edge k, then:
  - `busy` is high from edge k through edge k+2^N·(SETTLE+1).
  - `done` is high during the cycle after edge k+2^N·(SETTLE+1).
  - Earliest next accepted `start` is at edge k+2^N·(SETTLE+1)+2, in IDLE.
- `pass`, `mismatch_count` and `first_fail_*` are stable while `done` is high and remain so until the next accepted start.
- `dut_a` and `dut_b` are sampled only in SAMPLE; they may be asynchronous combinational functions of `vec_out`.

## Configuration
- `TT_CHECKER_STOP_ON_FAIL_EN` defined: in SAMPLE, the first mismatch sends the FSM directly to DONE, so the sweep aborts early. `mismatch_count` is then at most 1 and `vec_out` freezes at the failing vector.
- Not defined: the full 2^N sweep always runs and all mismatches are counted.

## Test plan
- N=2, SETTLE=1, both inputs driven by a correct x|~y, `start` at edge k:
  - `done` pulses after edge k+8.
  - `pass`=1, `mismatch_count`=0, `first_fail_valid`=0.
  - `vec_out` walks 00,01,10,11 at 2-cycle intervals.
- Same, but `dut_b` tied to 0, macro undefined (x|~y is 1,0,1,1 for vectors 00..11):
  - `mismatch_count`=3, `first_fail_vec`=2'b00, `first_fail_valid`=1, `pass`=0.
- Same fault, `TT_CHECKER_STOP_ON_FAIL_EN` defined:
  - `done` pulses after edge k+2.
  - `mismatch_count`=1, `first_fail_vec`=00, `vec_out`=00.
- SETTLE=3, N=2, correct unit:
  - `done` pulses after edge k+16.
  - `dut_a` and `dut_b` are sampled only on the 4th cycle of each vector, checked by glitching `dut_b` during DRIVE with no effect on the result.
- `start` held high during a sweep and during DONE: exactly one sweep runs; a new sweep begins only when `start` is seen in IDLE.
- Reset asserted at vector 10 mid-sweep, with `dut_b` faulty: on the next edge all outputs return to reset values (`busy`=0, `mismatch_count`=0); a fresh `start` sweeps from 00 again.
